// File: rtl/pp_pkg.sv
// pp_pkg: shared types and constants for the column-reduction slice.
//   NUM_SIZE    : element width, must match the ALU result width
//   red_op_t    : reduction opcodes
//   red_state_t : reducer FSM states
//   op_legal()  : true for opcodes that start a real reduction
package pp_pkg;

    localparam int NUM_SIZE = 32;

    typedef enum logic [3:0] {
        RED_NOOP  = 4'b0000,
        RED_SUM   = 4'b0001,
        RED_MIN   = 4'b0010,
        RED_MAX   = 4'b0011,
        RED_COUNT = 4'b0100
    } red_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } red_state_t;

    // NOOP is deliberately illegal: it would produce an empty result.
    function automatic logic op_legal(input logic [3:0] op);
        return (op == RED_SUM) || (op == RED_MIN) ||
               (op == RED_MAX) || (op == RED_COUNT);
    endfunction

endpackage

// File: rtl/pp_reduce_fold.sv
// pp_reduce_fold: combinational next-accumulator for one folded element.
//   op       : latched reduction opcode
//   acc      : current accumulator (signed, ACC_W)
//   first    : this is the first element folded since start
//   in_data  : signed element, sign-extended to ACC_W internally
//   acc_next : accumulator after folding in_data
module pp_reduce_fold
    import pp_pkg::*;
#(
    parameter int NUM_SIZE = pp_pkg::NUM_SIZE,
    parameter int ACC_W    = NUM_SIZE + 16
) (
    input  logic [3:0]          op,
    input  logic [ACC_W-1:0]    acc,
    input  logic                first,
    input  logic [NUM_SIZE-1:0] in_data,
    output logic [ACC_W-1:0]    acc_next
);

    logic [ACC_W-1:0] ext;

    assign ext = {{(ACC_W-NUM_SIZE){in_data[NUM_SIZE-1]}}, in_data};

    always_comb begin
        acc_next = acc;
        case (op)
            RED_SUM:   acc_next = acc + ext;
            // Strict compare: ties keep the value already held.
            RED_MIN:   acc_next = (first || ($signed(ext) < $signed(acc))) ? ext : acc;
            RED_MAX:   acc_next = (first || ($signed(ext) > $signed(acc))) ? ext : acc;
            // acc was cleared at start, so it tracks the folded count directly.
            RED_COUNT: acc_next = acc + ACC_W'(1);
            default:   acc_next = acc;
        endcase
    end

endmodule

// File: rtl/pp_reduce.sv
// pp_reduce: folds a column of signed ALU results into one scalar
// (SUM / MIN / MAX / COUNT) and holds it on a valid/ready output.
//   clk, reset          : clock, async active-high reset
//   start, op, len      : begin a reduction (sampled only in IDLE)
//   busy                : FSM not idle
//   in_valid/ready/data : element stream
//   in_null             : element is null (only with PP_REDUCE_SKIPNA_EN)
//   out_valid/ready     : result handshake
//   out_data/count/empty/err : result fields, stable while out_valid=1
// Optional feature macro: PP_REDUCE_SKIPNA_EN (null elements count toward
// len but are not folded).
module pp_reduce
    import pp_pkg::*;
#(
    parameter int NUM_SIZE = pp_pkg::NUM_SIZE,
    parameter int CNT_W    = 16,
    parameter int ACC_W    = NUM_SIZE + CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          op,
    input  logic [CNT_W-1:0]    len,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_SIZE-1:0] in_data,
`ifdef PP_REDUCE_SKIPNA_EN
    input  logic                in_null,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_data,
    output logic [CNT_W-1:0]    out_count,
    output logic                out_empty,
    output logic                out_err
);

    red_state_t       state;
    logic [3:0]       op_r;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] ecnt;       // elements consumed (null or not)
    logic [ACC_W-1:0] acc;
    logic             seen;       // at least one element folded
    logic [ACC_W-1:0] acc_next;
    logic             hs;
    logic             fold_now;
    logic             last;
    logic             fin_seen;
    logic [ACC_W-1:0] fin_acc;

`ifdef PP_REDUCE_SKIPNA_EN
    logic [CNT_W-1:0] fcnt;       // non-null elements folded
    assign fold_now = hs & ~in_null;
`else
    assign fold_now = hs;
`endif

    assign busy     = (state != IDLE);
    assign hs       = in_valid & in_ready;
    assign last     = hs && ((ecnt + CNT_W'(1)) == len_r);
    assign fin_seen = seen | fold_now;
    assign fin_acc  = fold_now ? acc_next : acc;

    pp_reduce_fold #(
        .NUM_SIZE (NUM_SIZE),
        .ACC_W    (ACC_W)
    ) u_fold (
        .op       (op_r),
        .acc      (acc),
        .first    (~seen),
        .in_data  (in_data),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_r      <= '0;
            len_r     <= '0;
            ecnt      <= '0;
            acc       <= '0;
            seen      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_empty <= 1'b0;
            out_err   <= 1'b0;
`ifdef PP_REDUCE_SKIPNA_EN
            fcnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // An illegal opcode wins over len=0.
                        if (!op_legal(op)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_count <= '0;
                            out_empty <= 1'b0;
                            out_err   <= 1'b1;
                        end else if (len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_count <= '0;
                            out_empty <= 1'b1;
                            out_err   <= 1'b0;
                        end else begin
                            state    <= ACCUM;
                            op_r     <= op;
                            len_r    <= len;
                            ecnt     <= '0;
                            acc      <= '0;
                            seen     <= 1'b0;
                            in_ready <= 1'b1;
`ifdef PP_REDUCE_SKIPNA_EN
                            fcnt     <= '0;
`endif
                        end
                    end
                end
                ACCUM: begin
                    if (hs) ecnt <= ecnt + CNT_W'(1);
                    if (fold_now) begin
                        acc  <= acc_next;
                        seen <= 1'b1;
`ifdef PP_REDUCE_SKIPNA_EN
                        fcnt <= fcnt + CNT_W'(1);
`endif
                    end
                    if (last) begin
                        state     <= DONE;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        // All-null column reports 0 rather than a stale acc.
                        out_data  <= fin_seen ? fin_acc : '0;
`ifdef PP_REDUCE_SKIPNA_EN
                        out_count <= fcnt + CNT_W'(fold_now);
                        out_empty <= ~fin_seen;
`else
                        out_count <= len_r;
                        out_empty <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pp_reduce.sv
module tb_pp_reduce;
    import pp_pkg::*;

    localparam int NS = 32;
    localparam int CW = 16;
    localparam int AW = NS + CW;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_null, out_ready;
    logic [3:0]    op;
    logic [CW-1:0] len;
    logic [NS-1:0] in_data;
    logic          busy, in_ready, out_valid, out_empty, out_err;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_count;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    pp_reduce #(.NUM_SIZE(NS), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef PP_REDUCE_SKIPNA_EN
        .in_null   (in_null),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_empty (out_empty),
        .out_err   (out_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: reduce the non-null elements with plain integer arithmetic.
    function automatic void model(input logic [3:0] o, input logic signed [31:0] el[$],
                                  input bit nl[$], output logic [AW-1:0] d,
                                  output logic [CW-1:0] c, output logic e, output logic r);
        longint res = 0;
        longint v;
        int k = 0;
        if (!(o inside {4'd1, 4'd2, 4'd3, 4'd4})) begin
            d = '0; c = '0; e = 1'b0; r = 1'b1;
            return;
        end
        for (int i = 0; i < el.size(); i++) begin
            if (nl[i]) continue;
            v = longint'(el[i]);
            case (o)
                4'd1: res = res + v;
                4'd2: res = (k == 0 || v < res) ? v : res;
                4'd3: res = (k == 0 || v > res) ? v : res;
                default: res = res + 1;
            endcase
            k++;
        end
        d = (k == 0) ? '0 : res[AW-1:0];
        c = CW'(k);
        e = (k == 0);
        r = 1'b0;
    endfunction

    task automatic run(input string tag, input logic [3:0] o, input logic signed [31:0] el[$],
                       input bit nl[$], input int mode, input int hold, input bit poke);
        logic [AW-1:0] ed;
        logic [CW-1:0] ec;
        logic ee, er, v, hs;
        int n, idx, cyc;
        n = el.size();
        model(o, el, nl, ed, ec, ee, er);
        @(negedge clk);
        start = 1'b1; op = o; len = CW'(n);
        @(negedge clk);
        start = 1'b0; op = 4'($urandom); len = CW'($urandom);
        chk({tag, " busy"}, 64'(busy), 64'd1);
        if (!er && n > 0) begin
            idx = 0; cyc = 0;
            while (idx < n && cyc < 200) begin
                chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
                chk({tag, " early_valid"}, 64'(out_valid), 64'd0);
                v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
                in_valid = v; in_data = el[idx]; in_null = nl[idx];
                if (poke && cyc == 1) begin
                    start = 1'b1; op = RED_COUNT; len = CW'(n + 3);
                end
                hs = v && in_ready;
                @(negedge clk);
                cyc++;
                start = 1'b0;
                if (hs) idx++;
            end
            in_valid = 1'b0; in_null = 1'b0;
            chk({tag, " consumed"}, 64'(idx), 64'(n));
        end
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " in_ready_off"}, 64'(in_ready), 64'd0);
        chk({tag, " out_data"}, 64'(out_data), 64'(ed));
        chk({tag, " out_count"}, 64'(out_count), 64'(ec));
        chk({tag, " out_empty"}, 64'(out_empty), 64'(ee));
        chk({tag, " out_err"}, 64'(out_err), 64'(er));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;  // must be ignored in DONE
            @(negedge clk);
            chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold_data"}, 64'(out_data), 64'(ed));
            chk({tag, " hold_count"}, 64'(out_count), 64'(ec));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, " idle"}, 64'(busy), 64'd0);
        chk({tag, " result_kept"}, 64'(out_data), 64'(ed));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [31:0] el[$];
        bit nl[$];
        reset = 1'b1; start = 1'b0; op = '0; len = '0;
        in_valid = 1'b0; in_data = '0; in_null = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst out_count", 64'(out_count), 64'd0);
        chk("rst out_empty", 64'(out_empty), 64'd0);
        chk("rst out_err", 64'(out_err), 64'd0);
        reset = 1'b0;

        // in_valid in IDLE must not be consumed
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;

        el = '{5, -3, 100, -2}; nl = '{0, 0, 0, 0};
        run("sum4", RED_SUM, el, nl, 0, 0, 1'b0);
        el = '{-7, 12, -7}; nl = '{0, 0, 0};
        run("min_held", RED_MIN, el, nl, 0, 0, 1'b0);
        run("max_held", RED_MAX, el, nl, 0, 0, 1'b0);
        run("min_tog", RED_MIN, el, nl, 1, 0, 1'b0);
        run("max_tog", RED_MAX, el, nl, 1, 0, 1'b0);
        run("count3", RED_COUNT, el, nl, 2, 1, 1'b0);

        el = {}; nl = {};
        run("len0", RED_SUM, el, nl, 0, 5, 1'b0);
        el = '{1, 2, 3}; nl = '{0, 0, 0};
        run("op1001", 4'b1001, el, nl, 0, 5, 1'b0);
        run("op_noop", RED_NOOP, el, nl, 0, 0, 1'b0);

        el = '{9, -4, 6, 1}; nl = '{0, 0, 0, 0};
        run("poke", RED_SUM, el, nl, 0, 0, 1'b1);

        // reset after 2 of 4 elements aborts immediately
        @(negedge clk);
        start = 1'b1; op = RED_SUM; len = 16'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 32'd7;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        el = '{-1, -1, 40}; nl = '{0, 0, 0};
        run("after_abort", RED_SUM, el, nl, 0, 0, 1'b0);

`ifdef PP_REDUCE_SKIPNA_EN
        el = '{10, 3, 4, 5}; nl = '{1, 0, 1, 0};
        run("skipna_sum", RED_SUM, el, nl, 0, 0, 1'b0);
        nl = '{1, 1, 1, 1};
        run("skipna_allnull", RED_MAX, el, nl, 0, 0, 1'b0);
`endif

        for (int t = 0; t < 25; t++) begin
            int n;
            el = {}; nl = {};
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) el.push_back(32'($urandom));
                else el.push_back(32'(int'($urandom_range(0, 6)) - 3));
`ifdef PP_REDUCE_SKIPNA_EN
                nl.push_back(bit'($urandom_range(0, 3) == 0));
`else
                nl.push_back(1'b0);
`endif
            end
            run("rand", 4'($urandom_range(1, 4)), el, nl, $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pp_reduce.md
Name: pp_reduce

Overview:
- Downstream consumer of the fixed-point ALU stage's result stream.
- Folds a column of signed NUM_SIZE results into one scalar using SUM, MIN, MAX or COUNT (pandas-style column reduction).
- Result is held on a valid/ready output port until the host/DMA side takes it.
- One reduction is in flight at a time, started by a start pulse that carries the opcode and the column length.

Parameters:
- NUM_SIZE, 32, width of each signed input element; must match the ALU result width.
- CNT_W, 16, width of the length and element counters; max column length is 2^CNT_W-1.
- ACC_W, NUM_SIZE+CNT_W, output/accumulator width; SUM cannot overflow at this width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a reduction; sampled only in IDLE
- op  in  4  reduction opcode, sampled with start
- len  in  CNT_W  number of elements to consume, sampled with start
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts an element
- in_data  in  NUM_SIZE  signed element (ALU result)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  signed result
- out_count  out  CNT_W  number of elements folded
- out_empty  out  1  no element was folded
- out_err  out  1  illegal opcode

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values: state=IDLE, busy=0, in_ready=0, out_valid=0, out_data=0, out_count=0, out_empty=0, out_err=0, accumulator=0, counters=0.
- Opcodes: RED_NOOP=4'b0000, RED_SUM=4'b0001, RED_MIN=4'b0010, RED_MAX=4'b0011, RED_COUNT=4'b0100.
- IDLE:
  - start=1 with a legal op other than NOOP and len>0: latch op and len, clear the accumulator, counters and first flag, go to ACCUM.
  - start=1 with len=0: go to DONE with out_data=0, out_count=0, out_empty=1.
  - start=1 with an illegal opcode (NOOP, or 5..15): go to DONE with out_err=1, out_data=0.
- ACCUM:
  - in_ready=1 and is a registered output.
  - Each handshake (in_valid & in_ready) folds in_data and increments the element counter.
  - The handshake that makes the element counter equal len moves to DONE; in_ready is 0 in the following cycle.
- Folding rules:
  - SUM: acc += sign-extended in_data.
  - MIN/MAX: the first folded element loads acc; later elements perform a signed compare-and-replace. Ties keep the existing value.
  - COUNT: acc = number of folded elements, zero-extended.
- DONE:
  - out_valid=1; out_data, out_count, out_empty and out_err stay stable while out_valid=1 and out_ready=0.
  - Handshake (out_valid & out_ready) returns to IDLE; out_valid=0 next cycle.
- Latency: out_valid rises the cycle after the last input handshake. Minimum start-to-out_valid is 2 cycles (start at t, first element accepted at t+1, out_valid at t+2).
- Result is not updated again until the next start.
- start while busy=1 is ignored: no queueing, no error.
- in_valid in IDLE or DONE is ignored and not consumed.
- Asynchronous reset mid-ACCUM or mid-DONE aborts immediately to IDLE; partial results are discarded.

Optional Feature:
- Macro: PP_REDUCE_SKIPNA_EN.
- Defined:
  - Adds port in_null (in, 1), qualified by the input handshake.
  - A null element counts toward len but is not folded.
  - out_count = number of non-null folded elements.
  - out_empty=1 if every element was null; out_data=0 in that case.
- Undefined:
  - No in_null port; every element is folded.
  - out_count equals the latched len.
  - out_empty=1 only for len=0.

Decomposition:
- Shared package pp_pkg holds:
  - NUM_SIZE
  - red_op_t, a 4-bit enum holding the opcodes above
  - red_state_t, an enum of IDLE, ACCUM, DONE
- One sub-module is natural: pp_reduce_fold, a combinational next-accumulator unit taking op, acc, first and in_data.
- The top level keeps the FSM, counters and handshake registers.

Test Plan:
- SUM, len=4, elements 5, -3, 100, -2 with in_valid held high -> out_data=100, out_count=4, out_valid exactly 1 cycle after the 4th handshake.
- MIN/MAX, len=3, elements -7, 12, -7 -> MIN out_data=-7 sign-extended; MAX out_data=12. Repeat with in_valid toggling 1/0 each cycle -> same results.
- len=0 SUM -> out_valid at t+1, out_empty=1, out_data=0. op=4'b1001 -> out_err=1. Hold out_ready=0 for 5 cycles -> outputs stable, then exactly one handshake.
- start pulsed during ACCUM with a different op/len -> ignored; original result returned. Assert reset after 2 of 4 elements -> busy=0, out_valid=0 the same cycle; a new start runs cleanly.
- With PP_REDUCE_SKIPNA_EN: SUM, len=4, elements 10(null), 3, 4(null), 5 -> out_data=8, out_count=2. All 4 elements null -> out_empty=1, out_data=0.
